// File: rtl/macro_issuer.sv
// macro_issuer: expands stack-calculator commands into calc micro-instruction
// sequences, buffers them in a DEPTH-entry FIFO and keeps a shadow stack height
// so push/pop guards are exact while instructions are still queued.
// Build option: define REJECT_CNT_EN to add the saturating reject_cnt output.
//
// state  | meaning
// S_IDLE | ready for a command; guard evaluated on the accepting edge
// S_EMIT | writing the latched command's sequence into the FIFO, one step per cycle
module macro_issuer #(
   parameter int DEPTH     = 4,
   parameter int STACK_MAX = 512,
   parameter int HW        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [3:0]    cmd_alu,
   input  logic [15:0]   cmd_lit,
   output logic          cmd_reject,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [31:0]   instr,
   output logic          busy,
   output logic [HW-1:0] height
`ifdef REJECT_CNT_EN
   ,
   output logic [15:0]   reject_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [HW-1:0] H_MAX = HW'(STACK_MAX);
   localparam logic [HW-1:0] H_ONE = HW'(1);
   localparam logic [HW-1:0] H_TWO = HW'(2);

   localparam logic [2:0] OP_DUP   = 3'd0;
   localparam logic [2:0] OP_PUSHL = 3'd1;
   localparam logic [2:0] OP_ARITH = 3'd2;
   localparam logic [2:0] OP_DROP  = 3'd3;
   localparam logic [2:0] OP_SHIFT = 3'd4;
   localparam logic [2:0] OP_SWAP  = 3'd5;

   localparam logic [3:0] U_SUB   = 4'h2;
   localparam logic [3:0] U_PUSH  = 4'h8;
   localparam logic [3:0] U_POP   = 4'h9;
   localparam logic [3:0] U_SHIFT = 4'hA;
   localparam logic [3:0] U_SETL  = 4'hB;
   localparam logic [3:0] U_PRINT = 4'hC;
   localparam logic [3:0] U_CLEAR = 4'hD;

   localparam logic [3:0] R0 = 4'd0;
   localparam logic [3:0] R1 = 4'd1;
   localparam logic [3:0] R2 = 4'd2;
   localparam logic [15:0] NOLIT = 16'h0000;

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   state_t          state, state_n;
   logic [2:0]      step, step_n;
   logic [2:0]      op_q;
   logic [3:0]      alu_q;
   logic [15:0]     lit_q;
   logic [HW-1:0]   height_n, h_guard;
   logic            guard_ok, accept, reject_n, do_write, seq_last, pop;
   logic [31:0]     seq_word;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;

   function automatic logic [31:0] uins(input logic [3:0] op, input logic [15:0] lit,
                                        input logic [3:0] rd, input logic [3:0] ra,
                                        input logic [3:0] rb);
      return {op, lit, rd, ra, rb};
   endfunction

   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready;
   assign instr       = mem[rd_ptr];
   assign busy        = (state == S_EMIT) || instr_valid;

   // Guard and resulting height for the command currently offered.
   always_comb begin
      guard_ok = 1'b0;
      h_guard  = height;
      case (cmd_op)
         OP_DUP:   begin guard_ok = (height >= H_ONE) && (height < H_MAX); h_guard = height + H_ONE; end
         OP_PUSHL: begin guard_ok = (height < H_MAX); h_guard = height + H_ONE; end
         OP_ARITH: begin
            guard_ok = (height >= H_TWO) && (cmd_alu >= 4'd1) && (cmd_alu <= 4'd5);
            h_guard  = height - H_ONE;
         end
         OP_DROP:  begin guard_ok = (height >= H_ONE); h_guard = height - H_ONE; end
         OP_SHIFT: guard_ok = (height >= H_ONE);
         OP_SWAP:  guard_ok = (height >= H_TWO);
         default:  guard_ok = 1'b0;
      endcase
   end

   // Micro-instruction for the latched command at the current step.
   always_comb begin
      seq_word = '0;
      seq_last = 1'b0;
      case (op_q)
         OP_DUP: case (step)
            3'd0:    seq_word = uins(U_POP,   NOLIT, R0, R0, R0);
            3'd1:    seq_word = uins(U_PUSH,  NOLIT, R0, R0, R0);
            3'd2:    seq_word = uins(U_PRINT, NOLIT, R0, R0, R0);
            default: begin seq_word = uins(U_PUSH, NOLIT, R0, R0, R0); seq_last = 1'b1; end
         endcase
         OP_PUSHL: case (step)
            3'd0:    seq_word = uins(U_SUB,   NOLIT, R0, R0, R0);
            3'd1:    seq_word = uins(U_SETL,  lit_q, R0, R0, R0);
            3'd2:    seq_word = uins(U_PRINT, NOLIT, R0, R0, R0);
            default: begin seq_word = uins(U_PUSH, NOLIT, R0, R0, R0); seq_last = 1'b1; end
         endcase
         OP_ARITH: case (step)
            3'd0:    seq_word = uins(U_POP,   NOLIT, R0, R0, R0);
            3'd1:    seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0);
            3'd2:    seq_word = uins(U_POP,   NOLIT, R1, R0, R0);
            3'd3:    seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0);
            3'd4:    seq_word = uins(alu_q,   NOLIT, R2, R1, R0);
            3'd5:    seq_word = uins(U_PRINT, NOLIT, R2, R0, R0);
            default: begin seq_word = uins(U_PUSH, NOLIT, R2, R0, R0); seq_last = 1'b1; end
         endcase
         OP_DROP: case (step)
            3'd0:    seq_word = uins(U_POP,   NOLIT, R0, R0, R0);
            default: begin seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0); seq_last = 1'b1; end
         endcase
         OP_SHIFT: case (step)
            3'd0:    seq_word = uins(U_POP,   NOLIT, R0, R0, R0);
            3'd1:    seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0);
            3'd2:    seq_word = uins(U_SHIFT, NOLIT, R0, R0, R0);
            3'd3:    seq_word = uins(U_SETL,  lit_q, R0, R0, R0);
            3'd4:    seq_word = uins(U_PRINT, NOLIT, R0, R0, R0);
            default: begin seq_word = uins(U_PUSH, NOLIT, R0, R0, R0); seq_last = 1'b1; end
         endcase
         OP_SWAP: case (step)
            3'd0:    seq_word = uins(U_POP,   NOLIT, R0, R0, R0);
            3'd1:    seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0);
            3'd2:    seq_word = uins(U_POP,   NOLIT, R1, R0, R0);
            3'd3:    seq_word = uins(U_CLEAR, NOLIT, R0, R0, R0);
            3'd4:    seq_word = uins(U_PRINT, NOLIT, R0, R0, R0);
            3'd5:    seq_word = uins(U_PUSH,  NOLIT, R0, R0, R0);
            3'd6:    seq_word = uins(U_PRINT, NOLIT, R1, R0, R0);
            default: begin seq_word = uins(U_PUSH, NOLIT, R1, R0, R0); seq_last = 1'b1; end
         endcase
         default: seq_last = 1'b1;
      endcase
   end

   // Next state: accept/reject in IDLE, emit one step per free FIFO slot in EMIT.
   always_comb begin
      state_n   = state;
      step_n    = step;
      height_n  = height;
      reject_n  = 1'b0;
      do_write  = 1'b0;
      accept    = 1'b0;
      cmd_ready = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (guard_ok) begin
                  accept   = 1'b1;
                  height_n = h_guard;
                  state_n  = S_EMIT;
                  step_n   = 3'd0;
               end else begin
                  reject_n = 1'b1;
               end
            end
         end
         S_EMIT: begin
            // A pop in the same cycle frees the slot even when the FIFO is full.
            if ((count != FULL) || pop) begin
               do_write = 1'b1;
               if (seq_last) begin
                  state_n = S_IDLE;
                  step_n  = 3'd0;
               end else begin
                  step_n = step + 3'd1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Control registers and the latched command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         step       <= 3'd0;
         height     <= '0;
         cmd_reject <= 1'b0;
         op_q       <= 3'd0;
         alu_q      <= 4'd0;
         lit_q      <= 16'd0;
      end else begin
         state      <= state_n;
         step       <= step_n;
         height     <= height_n;
         cmd_reject <= reject_n;
         if (accept) begin
            op_q  <= cmd_op;
            alu_q <= cmd_alu;
            lit_q <= cmd_lit;
         end
      end
   end

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= seq_word;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + AW'(1);
         if (pop)      rd_ptr <= rd_ptr + AW'(1);
         case ({do_write, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef REJECT_CNT_EN
   // Saturating count of reject pulses.
   always_ff @(posedge clk) begin
      if (rst) reject_cnt <= 16'd0;
      else if (cmd_reject && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_macro_issuer.sv
// Bench for macro_issuer: directed steps followed by a randomized command run,
// checked against a queue-based model of the expected instruction stream.
module tb_macro_issuer;
   localparam int DEPTH = 4;
   localparam int SMAX  = 3;
   localparam int HW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [3:0]    cmd_alu;
   logic [15:0]   cmd_lit;
   logic          cmd_reject;
   logic          instr_valid;
   logic          instr_ready;
   logic [31:0]   instr;
   logic          busy;
   logic [HW-1:0] height;
`ifdef REJECT_CNT_EN
   logic [15:0]   reject_cnt;
`endif

   macro_issuer #(.DEPTH(DEPTH), .STACK_MAX(SMAX), .HW(HW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_alu(cmd_alu), .cmd_lit(cmd_lit), .cmd_reject(cmd_reject),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .busy(busy), .height(height)
`ifdef REJECT_CNT_EN
      , .reject_cnt(reject_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] expq [$];
   int checks   = 0;
   int errors   = 0;
   int mh       = 0;
   int rdy_mode = 1;
   int exp_rcnt = 0;

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int u, input int lit, input int rd, input int ra, input int rb);
      return 32'((u << 28) | ((lit & 'hFFFF) << 12) | (rd << 8) | (ra << 4) | rb);
   endfunction

   function automatic bit legal(input int op, input int alu, input int h);
      case (op)
         0: return (h >= 1) && (h < SMAX);
         1: return h < SMAX;
         2: return (h >= 2) && (alu >= 1) && (alu <= 5);
         3: return h >= 1;
         4: return h >= 1;
         5: return h >= 2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int delta(input int op);
      if (op == 0 || op == 1) return 1;
      if (op == 2 || op == 3) return -1;
      return 0;
   endfunction

   // Append a command's micro-instruction sequence (SUB 2, SETL B, PUSH 8, POP 9,
   // SHIFT A, PRINT C, CLEAR D) to the expected stream.
   function automatic void expand(input int op, input int alu, input int lit);
      case (op)
         0: begin
            expq.push_back(mk(9,0,0,0,0));  expq.push_back(mk(8,0,0,0,0));
            expq.push_back(mk(12,0,0,0,0)); expq.push_back(mk(8,0,0,0,0));
         end
         1: begin
            expq.push_back(mk(2,0,0,0,0));  expq.push_back(mk(11,lit,0,0,0));
            expq.push_back(mk(12,0,0,0,0)); expq.push_back(mk(8,0,0,0,0));
         end
         2: begin
            expq.push_back(mk(9,0,0,0,0));  expq.push_back(mk(13,0,0,0,0));
            expq.push_back(mk(9,0,1,0,0));  expq.push_back(mk(13,0,0,0,0));
            expq.push_back(mk(alu,0,2,1,0));
            expq.push_back(mk(12,0,2,0,0)); expq.push_back(mk(8,0,2,0,0));
         end
         3: begin
            expq.push_back(mk(9,0,0,0,0));  expq.push_back(mk(13,0,0,0,0));
         end
         4: begin
            expq.push_back(mk(9,0,0,0,0));  expq.push_back(mk(13,0,0,0,0));
            expq.push_back(mk(10,0,0,0,0)); expq.push_back(mk(11,lit,0,0,0));
            expq.push_back(mk(12,0,0,0,0)); expq.push_back(mk(8,0,0,0,0));
         end
         5: begin
            expq.push_back(mk(9,0,0,0,0));  expq.push_back(mk(13,0,0,0,0));
            expq.push_back(mk(9,0,1,0,0));  expq.push_back(mk(13,0,0,0,0));
            expq.push_back(mk(12,0,0,0,0)); expq.push_back(mk(8,0,0,0,0));
            expq.push_back(mk(12,0,1,0,0)); expq.push_back(mk(8,0,1,0,0));
         end
         default: ;
      endcase
   endfunction

   task automatic set_rdy(input int mode);
      rdy_mode = mode;
      if (mode == 0) instr_ready = 1'b0;
      else if (mode == 1) instr_ready = 1'b1;
      else instr_ready = ($urandom_range(0, 3) != 0);
   endtask

   // One clock: score a pop that is about to happen, advance, then check busy.
   task automatic tick();
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
         if (expq.size() == 0) begin
            checks++; errors++;
            $error("FAIL unexpected_instr observed=%08h expected=none", instr);
         end else begin
            chk("instr", instr, expq.pop_front());
         end
      end
      @(posedge clk); #1;
      set_rdy(rdy_mode);
      chk("busy", 32'(busy), 32'(expq.size() != 0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      expq.delete();
      mh = 0;
      exp_rcnt = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send_cmd(input int op, input int alu, input int lit);
      int  n;
      bit  ok;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
      if (n == 200) begin
         checks++; errors++;
         $error("FAIL cmd_ready_timeout observed=0 expected=1");
      end else begin
         cmd_valid = 1'b1;
         cmd_op    = 3'(op);
         cmd_alu   = 4'(alu);
         cmd_lit   = 16'(lit);
         ok = legal(op, alu, mh);
         if (ok) begin
            expand(op, alu, lit);
            mh += delta(op);
         end else if (exp_rcnt < 65535) begin
            exp_rcnt++;
         end
         tick();
         cmd_valid = 1'b0;
         cmd_op    = 3'($urandom);
         cmd_alu   = 4'($urandom);
         cmd_lit   = 16'($urandom);
         chk("reject", 32'(cmd_reject), 32'(!ok));
         chk("height", 32'(height), 32'(mh));
      end
   endtask

   task automatic drain();
      int n;
      set_rdy(1);
      n = 0;
      while ((expq.size() != 0 || busy === 1'b1) && n < 200) begin tick(); n++; end
      chk("drain_empty", 32'(expq.size()), 32'd0);
      tick();
      chk("drain_valid", 32'(instr_valid), 32'd0);
   endtask

   initial begin
      int n;
      int op;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_alu = '0; cmd_lit = '0;
      instr_ready = 1'b0;
      rdy_mode = 0;

      // Reset state.
      do_reset();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_height", 32'(height), 32'd0);
      chk("rst_reject", 32'(cmd_reject), 32'd0);
`ifdef REJECT_CNT_EN
      chk("rst_reject_cnt", 32'(reject_cnt), 32'd0);
`endif

      // PUSHL 0x1234: first write one edge after accept, one instr per cycle.
      set_rdy(1);
      send_cmd(1, 0, 'h1234);
      chk("lat_valid_t0", 32'(instr_valid), 32'd0);
      tick();
      chk("lat_valid_t1", 32'(instr_valid), 32'd1);
      n = 1;
      while (busy === 1'b1 && n < 50) begin tick(); n++; end
      chk("pushl_cycles", 32'(n), 32'd5);
      chk("pushl_height", 32'(height), 32'd1);

      // PUSHL 5, PUSHL 3, ADD.
      do_reset();
      set_rdy(1);
      send_cmd(1, 0, 5);
      send_cmd(1, 0, 3);
      send_cmd(2, 1, 0);
      drain();
      chk("arith_height", 32'(height), 32'd1);

      // SWAP at height 1 is refused: one-cycle pulse, nothing queued.
      send_cmd(5, 0, 0);
      tick();
      chk("reject_pulse_end", 32'(cmd_reject), 32'd0);
      chk("reject_no_write", 32'(instr_valid), 32'd0);
      chk("reject_height", 32'(height), 32'd1);
`ifdef REJECT_CNT_EN
      chk("reject_cnt_one", 32'(reject_cnt), 32'(exp_rcnt));
`endif

      // SWAP with calc stalled: FIFO fills, then drains in order.
      send_cmd(1, 0, 'hBEEF);
      drain();
      set_rdy(0);
      send_cmd(5, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      drain();

      // Height boundaries with STACK_MAX = 3.
      send_cmd(0, 0, 0);
      send_cmd(1, 0, 'h7);
      send_cmd(0, 0, 0);
      send_cmd(1, 0, 'h8);
      chk("full_height", 32'(height), 32'(SMAX));
      send_cmd(2, 0, 0);
      send_cmd(2, 6, 0);
      send_cmd(6, 1, 0);
      send_cmd(7, 1, 0);
      send_cmd(3, 0, 0);
      send_cmd(4, 0, 'h55AA);
      send_cmd(2, 5, 0);
      send_cmd(3, 0, 0);
      send_cmd(3, 0, 0);
      send_cmd(4, 0, 1);
      send_cmd(2, 3, 0);
      drain();
`ifdef REJECT_CNT_EN
      tick();
      chk("reject_cnt_bound", 32'(reject_cnt), 32'(exp_rcnt));
`endif

      // Reset in the middle of a SHIFT expansion.
      send_cmd(1, 0, 9);
      drain();
      set_rdy(0);
      send_cmd(4, 0, 'h1111);
      tick(); tick(); tick();
      chk("mid_valid", 32'(instr_valid), 32'd1);
      rst = 1'b1;
      expq.delete();
      mh = 0;
      exp_rcnt = 0;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_height", 32'(height), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      tick(); tick();
      chk("mid_rst_abandon", 32'(instr_valid), 32'd0);
      send_cmd(3, 0, 0);
      send_cmd(1, 0, 'h4321);
      drain();

      // Randomized commands with random back-pressure.
      do_reset();
      set_rdy(2);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) op = $urandom_range(6, 7);
         else op = $urandom_range(0, 5);
         send_cmd(op, $urandom_range(0, 6), $urandom_range(0, 65535));
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      drain();
`ifdef REJECT_CNT_EN
      tick();
      chk("reject_cnt_rand", 32'(reject_cnt), 32'(exp_rcnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/macro_issuer.md
Name: macro_issuer

Overview:
- Expands high-level stack-calculator commands (DUP, PUSHL, ARITH, DROP, SHIFT, SWAP) into micro-instruction sequences for the calc core.
- Sequences are buffered in a parametrised FIFO.
- Tracks a shadow stack height, so guards are exact even while instructions are still queued.
- Sits between the button/switch front end (denoise pulses) and calc, replacing the fixed 4-entry queue and multi-state roll buffer with one generic expander.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
STACK_MAX, 512, calc stack capacity; push-type commands are refused when height == STACK_MAX
HW, 10, shadow height width; must hold STACK_MAX

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted this cycle
cmd_op  in  3  0 DUP, 1 PUSHL, 2 ARITH, 3 DROP, 4 SHIFT, 5 SWAP; 6/7 illegal
cmd_alu  in  4  ARITH opcode: 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD
cmd_lit  in  16  literal for PUSHL/SHIFT (switch value)
cmd_reject  out  1  one-cycle pulse: accepted command failed its guard
instr_valid  out  1  FIFO head valid
instr_ready  in  1  calc consumes head
instr  out  32  micro-instruction: [31:28] op, [27:12] lit, [11:8] rd, [7:4] ra, [3:0] rb; unused fields zero
busy  out  1  macro expansion in progress or FIFO non-empty
height  out  HW  shadow stack height

Behaviour:
- Micro-op codes: SUB 2, SETL 0xB, PUSH 8, POP 9, SHIFT 0xA, PRINT 0xC, CLEAR 0xD. The ALU op uses cmd_alu.
- Reset: FIFO emptied (pointers/count 0), height 0, state IDLE, step 0, cmd_reject 0, instr_valid 0. cmd_ready is 1 from the first cycle after reset.
- Reset mid-expansion abandons the remaining steps and discards all queued instructions.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/alu/lit and evaluate the guard against the current height:
    - Guard pass: apply height delta in the same edge, go to EMIT with step=0.
    - Guard fail: cmd_reject=1 for the next cycle, stay in IDLE, nothing is queued.
  - EMIT: cmd_ready=0. Each cycle, write sequence[step] if count<DEPTH or a pop occurs the same cycle; otherwise hold. Increment step. After the last step, go to IDLE.
- Guards and height deltas:
  - DUP: 1<=h<STACK_MAX, +1
  - PUSHL: h<STACK_MAX, +1
  - ARITH: h>=2 and alu in 1..5, -1
  - DROP: h>=1, -1
  - SHIFT: h>=1, 0
  - SWAP: h>=2, 0
  - Illegal op: always reject.
- Sequences (emission order, regs r0/r1/r2):
  - DUP: POP r0; PUSH r0; PRINT r0; PUSH r0
  - PUSHL: SUB r0=r0-r0; SETL r0,lit; PRINT r0; PUSH r0
  - ARITH: POP r0; CLEAR; POP r1; CLEAR; alu rd=r2,ra=r1,rb=r0; PRINT r2; PUSH r2
  - DROP: POP r0; CLEAR
  - SHIFT: POP r0; CLEAR; SHIFT r0; SETL r0,lit; PRINT r0; PUSH r0
  - SWAP: POP r0; CLEAR; POP r1; CLEAR; PRINT r0; PUSH r0; PRINT r1; PUSH r1
  - Step counter is 3 bits, max 8 steps.
- Register fields: the register for single-operand ops goes in rd.
- Latency: command accepted at edge T; first instruction written at edge T+1; instr_valid high in the cycle after T+1 (FIFO initially empty).
- Throughput: one instruction per cycle when calc keeps instr_ready=1.
- FIFO:
  - instr is driven from mem[rd_ptr].
  - Pop on instr_valid&instr_ready.
  - Pointers wrap mod DEPTH.
  - Push and pop in the same cycle is allowed when full; count is unchanged.
  - No write occurs when full without a pop.
- cmd_lit/cmd_alu changes after acceptance have no effect.
- Height never wraps because the guards prevent over/underflow.

Optional Feature:
- REJECT_CNT_EN: adds output reject_cnt[15:0].
  - Increments on every cmd_reject pulse and saturates at 0xFFFF.
  - Reset to 0.
- Without the macro the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, PUSHL lit=0x1234, instr_ready=1 -> 4 instrs: 0x20000000, 0xB1234000, 0xC0000000, 0x80000000; height=1.
- PUSHL 5, PUSHL 3, ARITH alu=1 -> 7 instrs ending with 0x10000210, 0xC0000200, 0x80000200; height=1.
- Height=1, SWAP -> cmd_reject pulse 1 cycle, no FIFO write, height stays 1; with REJECT_CNT_EN, reject_cnt=1.
- DEPTH=4, instr_ready=0, SWAP at h=2 -> 4 writes then stall, cmd_ready=0, busy=1; release instr_ready -> remaining 4 in order, no loss or duplication.
- STACK_MAX=2: PUSHL x3 -> third rejected, height=2; then DROP -> height=1, instrs 0x90000000, 0xD0000000.
- Assert rst mid-SHIFT after 3 emissions -> next cycle instr_valid=0, height=0, cmd_ready=1.
